even_parity_checker: RTL
========================

# even_parity_checker

Serial receive-side checker for the team's even-parity scheme. It accepts one bit per handshake: DATA_W data bits LSB-first, then one parity bit. It reassembles the data word, flags any parity mismatch, and presents the word and flag on a valid/ready output port. It sits at the receiving end of any link whose transmitter uses the team's XOR-of-all-bits even parity generator.

## Interface
Parameters:
- DATA_W, 4: data bits per frame, excluding parity; ≥1.
- CNT_W, 8: width of the error counter (used only when the counter is configured in).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- bit_in  in  1  serial data or parity bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  checker accepts a bit this cycle.
- frame_data  out  DATA_W  reassembled data word.
- frame_err  out  1  1 = parity mismatch in this frame.
- frame_valid  out  1  frame_data and frame_err are valid.
- frame_ready  in  1  downstream accepts the frame.
- busy  out  1  a partial frame is held (state DATA with bits received, or state PARITY).
- err_clr  in  1  clears err_count (present only with the counter macro).
- err_count  out  CNT_W  saturating count of errored frames (present only with the counter macro).

## Operation
- Bit accept: bit_valid && bit_ready. Frame accept: frame_valid && frame_ready.
- The state machine has three states:
  - DATA: bit_ready=1. Each accepted bit is written into shift[idx], then idx increments. The running XOR register is updated as `run ^= bit_in`. After the accepted bit with idx==DATA_W-1, go to PARITY.
  - PARITY: bit_ready=1. On an accepted bit:
    - frame_err_q <= run ^ bit_in (0 when the total count of ones is even).
    - frame_data_q <= shift.
    - Go to HOLD.
  - HOLD: bit_ready=0 and frame_valid=1. frame_data and frame_err stay stable. bits arriving while bit_valid is high are ignored. On frame accept, clear idx and run, then go to DATA.
- frame_valid is high in HOLD only.
- If bit_valid stays low, the state does not change. Gaps between bits are legal in any state.
- Reset (also mid-frame) discards any partial frame and returns to DATA.
- Reset values of the outputs:
  - bit_ready=1, frame_valid=0, frame_data=0, frame_err=0, busy=0, err_count=0.
  - Internal: idx=0, run=0.

## Timing
- Latency: frame_valid rises on the cycle after the parity bit is accepted.
- Throughput: DATA_W+1 accepted bits per frame, plus at least one HOLD cycle in which bit_ready=0. The next frame's first bit can be accepted on the cycle after frame accept.
- With frame_ready tied high, the maximum rate is one frame per DATA_W+2 cycles.
- All outputs are registered, or decoded directly from the state register. There is no combinational path from frame_ready to bit_ready.

## Configuration
- PARITY_ERR_CNT_EN defined:
  - The err_clr and err_count ports exist.
  - err_count increments on the same edge that loads frame_err_q=1, and saturates at 2^CNT_W-1.
  - If err_clr and an increment occur in the same cycle, clear wins and err_count=0.
  - Reset value is 0.
- PARITY_ERR_CNT_EN undefined:
  - The err_clr and err_count ports are absent and no counter logic exists.
  - All other behaviour is identical.

## Structure
- Package even_parity_pkg holds:
  - typedef enum logic [1:0] {DATA, PARITY, HOLD} chk_state_t.
  - localparam DEFAULT_DATA_W = 4.
- Sub-module parity_err_counter (parameter CNT_W; ports inc, clr, count), instantiated only under PARITY_ERR_CNT_EN.
- The FSM, shift register and bit index stay in even_parity_checker.

## Test plan
1. DATA_W=4, bits 1,0,1,1 then parity 1 (data 4'hD, ones=3+1) → frame_data=4'hD, frame_err=0. frame_valid rises one cycle after the parity accept.
2. Bits 1,1,0,0 (4'h3) then parity 1 → frame_err=1. With the macro, err_count goes 0→1.
3. Backpressure: frame_ready held low for 5 cycles in HOLD while bit_valid toggles → frame_valid stays 1, frame_data/frame_err are stable, bit_ready=0, and no bits are consumed. After frame_ready rises, the next frame decodes correctly.
4. Random 0–3 cycle gaps in bit_valid across data 4'hA, parity 0 → frame_data=4'hA, frame_err=0.
5. rst_n low for one cycle after 2 bits, then a full frame 4'h6 with parity 0 → frame_data=4'h6, frame_err=0, with no residue from the aborted frame.
6. Macro defined, CNT_W=2, 5 errored frames → err_count=3 (saturated). err_clr pulsed in the same cycle as a 6th error → err_count=0.

Source files
------------

// File: rtl/even_parity_pkg.sv
// Shared types and defaults for the even-parity receive checker.
// Exports: chk_state_t (DATA, PARITY, HOLD), DEFAULT_DATA_W.
package even_parity_pkg;

  typedef enum logic [1:0] {
    DATA,
    PARITY,
    HOLD
  } chk_state_t;

  localparam int DEFAULT_DATA_W = 4;

endpackage

// File: rtl/parity_err_counter.sv
// Saturating counter of frames that failed the parity check.
// Ports: clk, rst_n (sync, active-low), inc, clr (wins over inc), count.
module parity_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/even_parity_checker.sv
// Serial even-parity checker: DATA_W bits LSB-first then a parity bit,
// word and error flag presented on a valid/ready frame port.
// Ports: clk, rst_n (sync, active-low), bit_in/bit_valid/bit_ready,
// frame_data/frame_err/frame_valid/frame_ready, busy.
// Build option PARITY_ERR_CNT_EN adds err_clr and err_count.
module even_parity_checker
  import even_parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy
`ifdef PARITY_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

  chk_state_t        state;
  chk_state_t        state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift;
  logic              run;
  logic              acc;
  logic              par_err;

  assign acc     = bit_valid && bit_ready;
  assign par_err = run ^ bit_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DATA;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_ready   = 1'b0;
    frame_valid = 1'b0;
    unique case (state)
      DATA: begin
        bit_ready = 1'b1;
        if (bit_valid && (idx == LAST)) begin
          state_nxt = PARITY;
        end
      end
      PARITY: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        frame_valid = 1'b1;
        if (frame_ready) begin
          state_nxt = DATA;
        end
      end
      default: state_nxt = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      run        <= 1'b0;
      shift      <= '0;
      frame_data <= '0;
      frame_err  <= 1'b0;
    end else begin
      if (acc && (state == DATA)) begin
        shift[idx] <= bit_in;
        run        <= run ^ bit_in;
        idx        <= idx + 1'b1;
      end
      if (acc && (state == PARITY)) begin
        frame_err  <= par_err;
        frame_data <= shift;
      end
      if ((state == HOLD) && frame_ready) begin
        idx <= '0;
        run <= 1'b0;
      end
    end
  end

  assign busy = (state == PARITY) ||
                ((state == DATA) && (idx != '0));

`ifdef PARITY_ERR_CNT_EN
  parity_err_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (acc && (state == PARITY) && par_err),
    .clr  (err_clr),
    .count(err_count)
  );
`endif

endmodule
